// File: rtl/sd_level_detector.sv
// Hysteresis level detector for sigma-delta magnitude samples.
// Emits rise/fall events (fall carries burst peak and duration) through a one-entry valid/ready register.
module sd_level_detector #(
  parameter int WIDTH     = 16,
  parameter int HOLD      = 64,
  parameter int DUR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     in,
  input  logic [WIDTH-1:0]     thHigh,
  input  logic [WIDTH-1:0]     thLow,
  output logic                 active,
  output logic                 eventValid,
  input  logic                 eventReady,
  output logic                 eventRise,
  output logic [WIDTH-1:0]     eventPeak,
  output logic [DUR_WIDTH-1:0] eventDuration,
  output logic                 overrun
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_C = HW'(HOLD);

  typedef enum logic [1:0] {QUIET, ACTIVE, RELEASE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_peak, w_peak_nxt, w_peak_max;
  logic [DUR_WIDTH-1:0] r_dur, w_dur_nxt, w_dur_inc;
  logic [HW-1:0]        r_hold, w_hold_nxt, w_hold_inc;
  logic                 r_active;
  logic                 w_above, w_below;
  logic                 w_emit, w_emit_rise, w_new_ev;
  logic [WIDTH-1:0]     w_ev_peak;
  logic [DUR_WIDTH-1:0] w_ev_dur;

  logic                 r_ev_valid, r_ev_rise, r_overrun;
  logic [WIDTH-1:0]     r_ev_peak;
  logic [DUR_WIDTH-1:0] r_ev_dur;

  always_comb begin
    w_above     = (in >= thHigh);
    w_below     = (in < thLow);
    w_peak_max  = (in > r_peak) ? in : r_peak;
    w_dur_inc   = (&r_dur) ? r_dur : r_dur + 1'b1;
    w_hold_inc  = r_hold + 1'b1;
    w_state_nxt = r_state;
    w_peak_nxt  = r_peak;
    w_dur_nxt   = r_dur;
    w_hold_nxt  = r_hold;
    w_emit      = 1'b0;
    w_emit_rise = 1'b0;
    w_ev_peak   = w_peak_max;
    w_ev_dur    = w_dur_inc;
    case (r_state)
      QUIET: begin
        // Above wins even if the sample is also below (thLow > thHigh).
        if (w_above) begin
          w_state_nxt = ACTIVE;
          w_peak_nxt  = in;
          w_dur_nxt   = DUR_WIDTH'(1);
          w_hold_nxt  = '0;
          w_emit      = 1'b1;
          w_emit_rise = 1'b1;
          w_ev_peak   = in;
          w_ev_dur    = DUR_WIDTH'(1);
        end
      end
      ACTIVE: begin
        w_peak_nxt = w_peak_max;
        w_dur_nxt  = w_dur_inc;
        if (w_below) begin
          if (HOLD == 1) begin
            w_state_nxt = QUIET;
            w_emit      = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
            w_hold_nxt  = HW'(1);
          end
        end
      end
      RELEASE: begin
        w_peak_nxt = w_peak_max;
        w_dur_nxt  = w_dur_inc;
        if (!w_below) begin
          w_state_nxt = ACTIVE;
          w_hold_nxt  = '0;
        end else if (w_hold_inc == HOLD_C) begin
          w_state_nxt = QUIET;
          w_hold_nxt  = '0;
          w_emit      = 1'b1;
        end else begin
          w_hold_nxt  = w_hold_inc;
        end
      end
      default: w_state_nxt = QUIET;
    endcase
  end

  assign w_new_ev = en & w_emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= QUIET;
      r_peak   <= '0;
      r_dur    <= '0;
      r_hold   <= '0;
      r_active <= 1'b0;
    end else if (en) begin
      r_state  <= w_state_nxt;
      r_peak   <= w_peak_nxt;
      r_dur    <= w_dur_nxt;
      r_hold   <= w_hold_nxt;
      r_active <= (w_state_nxt != QUIET);
    end
  end

  // Event register: a same-edge consume frees the slot for a new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_rise  <= 1'b0;
      r_ev_peak  <= '0;
      r_ev_dur   <= '0;
      r_overrun  <= 1'b0;
    end else if (w_new_ev && (!r_ev_valid || eventReady)) begin
      r_ev_valid <= 1'b1;
      r_ev_rise  <= w_emit_rise;
      r_ev_peak  <= w_ev_peak;
      r_ev_dur   <= w_ev_dur;
    end else if (w_new_ev) begin
      r_overrun  <= 1'b1;
    end else if (eventReady) begin
      r_ev_valid <= 1'b0;
    end
  end

  assign active        = r_active;
  assign eventValid    = r_ev_valid;
  assign eventRise     = r_ev_rise;
  assign eventPeak     = r_ev_peak;
  assign eventDuration = r_ev_dur;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_sd_level_detector.sv
// Bench for sd_level_detector: directed scenarios plus random traffic against a burst-history model.
module tb_sd_level_detector;
  localparam int WIDTH = 16;
  localparam int HOLD  = 4;
  localparam int TH    = 1000;
  localparam int TL    = 800;
  localparam int DMAX  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic [WIDTH-1:0] thHigh = 16'(TH);
  logic [WIDTH-1:0] thLow  = 16'(TL);
  logic eventReady = 1'b1;
  logic active, eventValid, eventRise, overrun;
  logic [WIDTH-1:0] eventPeak;
  logic [15:0] eventDuration;
  logic s_active, s_valid, s_rise, s_overrun;
  logic [WIDTH-1:0] s_peak;
  logic [3:0] s_dur;

  sd_level_detector #(.WIDTH(WIDTH), .HOLD(HOLD), .DUR_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .thHigh(thHigh), .thLow(thLow),
    .active(active), .eventValid(eventValid), .eventReady(eventReady),
    .eventRise(eventRise), .eventPeak(eventPeak), .eventDuration(eventDuration),
    .overrun(overrun));

  sd_level_detector #(.WIDTH(WIDTH), .HOLD(HOLD), .DUR_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in(in), .thHigh(thHigh), .thLow(thLow),
    .active(s_active), .eventValid(s_valid), .eventReady(eventReady),
    .eventRise(s_rise), .eventPeak(s_peak), .eventDuration(s_dur),
    .overrun(s_overrun));

  always #5 clk = ~clk;

  typedef struct { bit rise; int peak; int dur; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  // Model: the burst is kept as its full sample history.
  bit  m_inb, m_pend, m_ovr;
  int  m_samp[$];
  bit  m_blw[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inb = 0; m_pend = 0; m_ovr = 0;
    m_samp.delete(); m_blw.delete(); exp_q.delete();
  endtask

  task automatic model_edge(input bit e, input int x, input bit rdy);
    bit newev = 0;
    bit cons;
    ev_t ne;
    int trail, pk;
    if (e) begin
      if (!m_inb) begin
        if (x >= TH) begin
          m_inb = 1; m_samp = {x}; m_blw = {1'b0};
          ne = '{1'b1, x, 1}; newev = 1;
        end
      end else begin
        m_samp.push_back(x); m_blw.push_back(x < TL);
        trail = 0;
        for (int i = m_blw.size() - 1; i >= 0 && m_blw[i]; i--) trail++;
        if (trail >= HOLD) begin
          pk = 0;
          foreach (m_samp[i]) if (m_samp[i] > pk) pk = m_samp[i];
          ne = '{1'b0, pk, (m_samp.size() > DMAX) ? DMAX : m_samp.size()};
          newev = 1; m_inb = 0; m_samp.delete(); m_blw.delete();
        end
      end
    end
    cons = m_pend && rdy;
    if (newev) begin
      if (!m_pend || cons) begin exp_q.push_back(ne); m_pend = 1; end
      else m_ovr = 1;
    end else if (cons) m_pend = 0;
  endtask

  task automatic step(input bit e, input int x, input bit rdy);
    @(negedge clk);
    rst = 0; en = e; in = 16'(x); eventReady = rdy;
    model_edge(e, x, rdy);
    @(posedge clk); #1;
    chk("active", active, m_inb);
    chk("eventValid", eventValid, m_pend);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 1; in = 16'd1200; eventReady = 1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_active", active, 0);
    chk("rst_valid", eventValid, 0);
    chk("rst_rise", eventRise, 0);
    chk("rst_peak", eventPeak, 0);
    chk("rst_dur", eventDuration, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // Monitor: the event on the port must match the scoreboard head while valid;
  // it is retired on a handshake edge.
  always @(posedge clk) begin
    if (!rst && eventValid) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_event actual=valid expected=none at %0t", $time);
      end else begin
        chk("ev_rise", eventRise, exp_q[0].rise);
        chk("ev_peak", eventPeak, exp_q[0].peak);
        chk("ev_dur", eventDuration, exp_q[0].dur);
        if (eventReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // Rise after quiet input
    repeat (10) step(1, 0, 1);
    step(1, 1200, 1);
    chk("rise_peak", eventPeak, 1200);
    chk("rise_dur", eventDuration, 1);
    step(1, 1200, 1);
    // Hysteresis and hold: fall only on the 4th consecutive below
    do_reset();
    step(1, 1200, 1);
    repeat (20) step(1, 900, 1);
    repeat (3) step(1, 700, 1);
    step(1, 900, 1);
    repeat (4) step(1, 700, 1);
    chk("fall_rise", eventRise, 0);
    chk("fall_peak", eventPeak, 1200);
    chk("fall_dur", eventDuration, 29);
    // Backpressure: rise held, fall dropped, overrun sticky
    do_reset();
    step(1, 1200, 0);
    repeat (4) step(1, 700, 0);
    step(0, 0, 1);
    repeat (3) step(1, 0, 1);
    chk("overrun_sticky", overrun, 1);
    // Enable gating
    do_reset();
    for (int i = 0; i < 12; i++) step(i % 2 == 0, (i % 2 == 0) ? 0 : 5000, 1);
    step(1, 5000, 1);
    chk("gate_rise", eventRise, 1);
    // Saturation on the 4-bit duration instance
    do_reset();
    repeat (20) step(1, 1200, 1);
    repeat (4) step(1, 700, 1);
    chk("sat_valid", s_valid, 1);
    chk("sat_rise", s_rise, 0);
    chk("sat_peak", s_peak, 1200);
    chk("sat_dur", s_dur, 15);
    // Reset mid-burst with a pending event
    do_reset();
    step(1, 1200, 0);
    step(1, 1300, 0);
    do_reset();
    step(1, 1200, 1);
    chk("fresh_dur", eventDuration, 1);
    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r, x;
      r = $urandom_range(0, 99);
      if (r < 45) x = $urandom_range(0, TL - 1);
      else if (r < 75) x = $urandom_range(TL, TH - 1);
      else x = $urandom_range(TH, 65535);
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 8, x, $urandom_range(0, 9) < 7);
    end
    step(0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
